// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART TX framer.
//   tx_state_e : frame FSM states
//   tx_sel_e   : output-mux select codes (0..4, anything else drives the idle level)
//   PAR_*      : parity type codes for PAR_TYP
//   STOP_LAST_*: index of the final stop cycle for one / two stop bits
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [3:0] {
    SEL_IDLE   = 4'd0,
    SEL_START  = 4'd1,
    SEL_DATA   = 4'd2,
    SEL_PARITY = 4'd3,
    SEL_STOP   = 4'd4
  } tx_sel_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic STOP_LAST_1 = 1'b0;
  localparam logic STOP_LAST_2 = 1'b1;

  function automatic tx_sel_e state_to_sel(input tx_state_e s);
    case (s)
      START:   return SEL_START;
      DATA:    return SEL_DATA;
      PARITY:  return SEL_PARITY;
      STOP:    return SEL_STOP;
      default: return SEL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_out_mux.sv
// Registered select-to-line mux. Because the line comes straight off a flop
// it can never glitch while the select/data inputs settle.
//   clk, rst_n : clock, async active-low reset (line returns to IDLE_LEVEL)
//   sel        : what the line carries next cycle
//   ser_bit    : next serial data bit
//   par_bit    : latched parity bit
//   tx_out     : serial line
module uart_tx_out_mux
  import uart_tx_pkg::*;
#(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  tx_sel_e sel,
  input  logic    ser_bit,
  input  logic    par_bit,
  output logic    tx_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_out <= IDLE_LEVEL;
    else begin
      case (sel)
        SEL_START:  tx_out <= 1'b0;
        SEL_DATA:   tx_out <= ser_bit;
        SEL_PARITY: tx_out <= par_bit;
        default:    tx_out <= IDLE_LEVEL;  // idle, stop and unused codes
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART TX framer: start bit, DATA_WIDTH payload bits LSB first, optional
// parity, one or two stop bits. One bit per CLK. A new frame can be taken
// in the last stop cycle, so frames run back to back without a gap.
//   CLK, RST   : clock, async active-low reset
//   P_DATA     : payload, captured on ACCEPT
//   DATA_VALID : request; held by upstream until ACCEPT
//   PAR_EN/PAR_TYP/STOP2 : frame config, captured on ACCEPT
//   TX_OUT     : registered serial line
//   BUSY       : registered, high for every cycle a frame occupies the line
//   ACCEPT     : combinational, payload/config taken this cycle
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  ACCEPT
);

  localparam int            CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  tx_state_e             state, state_nxt;
  logic [CW-1:0]         bit_cnt;
  logic                  stop_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_q, par_en_q, stop2_q;
  logic                  last_stop, ser_nxt;
  tx_sel_e               sel_nxt;

  assign last_stop = (state == STOP) &&
                     (stop_cnt == (stop2_q ? STOP_LAST_2 : STOP_LAST_1));
  assign ACCEPT    = DATA_VALID && ((state == IDLE) || last_stop);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ACCEPT) state_nxt = START;
      START:   state_nxt = DATA;
      DATA:    if (bit_cnt == CNT_LAST) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  state_nxt = STOP;
      STOP:    if (last_stop) state_nxt = ACCEPT ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The out-mux registers the *next* bit so TX_OUT moves on the same edge
  // as the state. The shift register holds the current bit in [0], so the
  // bit after it is [1]; leaving START, bit 0 is next.
  assign ser_nxt = (state == START) ? shreg[0] : shreg[1];
  assign sel_nxt = state_to_sel(state_nxt);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      BUSY     <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      BUSY  <= (state_nxt != IDLE);
      case (state)
        DATA: begin
          shreg   <= shreg >> 1;
          bit_cnt <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
        end
        STOP:    stop_cnt <= last_stop ? 1'b0 : 1'b1;
        default: ;
      endcase
      // Capture last so an accept in the final stop cycle wins.
      if (ACCEPT) begin
        shreg    <= P_DATA;
        par_q    <= (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
        par_en_q <= PAR_EN;
        stop2_q  <= STOP2;
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
      end
    end
  end

  uart_tx_out_mux #(.IDLE_LEVEL(IDLE_LEVEL)) u_out_mux (
    .clk    (CLK),
    .rst_n  (RST),
    .sel    (sel_nxt),
    .ser_bit(ser_nxt),
    .par_bit(par_q),
    .tx_out (TX_OUT)
  );

endmodule
